// File: rtl/pin_read_arbiter_pkg.sv
// Shared pin-width constants, the stage-1 snapshot record and a popcount helper
// for the GPIO read arbiter.
package pin_read_arbiter_pkg;

  localparam int IO_PINS   = 16;
  localparam int PIN_CNT_W = $clog2(IO_PINS + 1);

  typedef struct packed {
    logic [IO_PINS-1:0] mask;
    logic [IO_PINS-1:0] pins;
  } pin_snap_t;

  function automatic logic [PIN_CNT_W-1:0] popcount(input logic [IO_PINS-1:0] v);
    logic [PIN_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < IO_PINS; i++) begin
      c = c + PIN_CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pin_read_arbiter_if.sv
// Core-side read bus: per-core request and mask in, one-hot grant and the
// tagged compressed result out. Master = cores, slave = arbiter.
interface pin_read_arbiter_if
  import pin_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = PIN_CNT_W
);

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*IO_PINS-1:0] req_mask;
  logic [NUM_REQ-1:0]         gnt;
  logic                       rd_valid;
  logic [ID_W-1:0]            rd_id;
  logic [IO_PINS-1:0]         rd_data;
  logic [CNT_W-1:0]           rd_count;

  modport master (
    output req, req_mask,
    input  gnt, rd_valid, rd_id, rd_data, rd_count
  );

  modport slave (
    input  req, req_mask,
    output gnt, rd_valid, rd_id, rd_data, rd_count
  );

endinterface

// File: rtl/pin_read_arbiter_compress.sv
// Packs the masked pins down to the low bits, lowest-order masked pin at bit 0.
// Purely combinational; bits above the mask popcount are zero.
module pin_compress #(
  parameter int W = 16
) (
  input  logic [W-1:0] pins,
  input  logic [W-1:0] mask,
  output logic [W-1:0] data
);

  int unsigned pos;

  always_comb begin
    data = '0;
    pos  = 0;
    for (int i = 0; i < W; i++) begin
      if (mask[i]) begin
        data[pos] = pins[i];
        pos       = pos + 1;
      end
    end
  end

endmodule

// File: rtl/pin_read_arbiter.sv
// Round-robin shares one pin_compress among NUM_REQ cores; grant is combinational,
// result returns 2 cycles after grant. No backpressure: requests are held until gnt.
module pin_read_arbiter
  import pin_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int CNT_W       = PIN_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IO_PINS-1:0] io_in,
  pin_read_arbiter_if.slave  bus
);

  logic [IO_PINS-1:0] sync_q [SYNC_STAGES];
  logic [IO_PINS-1:0] io_sync;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [ID_W-1:0]    winner;
  logic               found;
  int                 j;
  logic [NUM_REQ-1:0] gnt_c;
  logic [IO_PINS-1:0] win_mask;

  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  pin_snap_t          s1_snap;
  logic [IO_PINS-1:0] cmp_data;

  logic               rd_valid_q;
  logic [ID_W-1:0]    rd_id_q;
  logic [IO_PINS-1:0] rd_data_q;
  logic [CNT_W-1:0]   rd_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign io_sync = sync_q[SYNC_STAGES-1];

  // Scan from ptr upward, wrapping; the first live request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    j      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req[j]) begin
        found  = 1'b1;
        winner = ID_W'(j);
      end
    end
  end

  always_comb begin
    gnt_c    = '0;
    win_mask = '0;
    if (found) begin
      gnt_c[winner] = 1'b1;
      win_mask      = bus.req_mask[winner*IO_PINS +: IO_PINS];
    end
    ptr_nxt = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  assign bus.gnt = gnt_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_snap  <= '0;
    end else begin
      s1_valid     <= found;
      s1_id        <= winner;
      s1_snap.mask <= win_mask;
      s1_snap.pins <= io_sync;
    end
  end

  pin_compress #(
    .W(IO_PINS)
  ) u_compress (
    .pins (s1_snap.pins),
    .mask (s1_snap.mask),
    .data (cmp_data)
  );

  // Result fields only move alongside a valid pulse so cores can sample lazily.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_data_q  <= '0;
      rd_count_q <= '0;
    end else begin
      rd_valid_q <= s1_valid;
      if (s1_valid) begin
        rd_id_q    <= s1_id;
        rd_data_q  <= cmp_data;
        rd_count_q <= CNT_W'(popcount(s1_snap.mask));
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_id    = rd_id_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_count = rd_count_q;

endmodule

// File: doc/pin_read_arbiter.md
# pin_read_arbiter

Shares one `pin_compress` instance among `NUM_REQ` cores that read packed subsets of the GPIO inputs. Each core asks for a read with its own pin mask; a round-robin arbiter grants one request per cycle. Two registered stages then snapshot the synchronized pins, compress them under the winner's mask, and return the packed word tagged with the requester id. The block sits between the I/O pad inputs and the per-core I/O read ports.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `SYNC_STAGES`, default 2: synchronizer depth on `io_in`, at least 1.
- `ID_W`, default `$clog2(NUM_REQ)`: requester id width (derived).
- `CNT_W`, default `$clog2(`IO_PINS+1)`: popcount width (derived).

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `io_in`, input, `IO_PINS: raw pad inputs, asynchronous to `clk`.
- `req`, input, NUM_REQ: read request per core, held until granted.
- `req_mask`, input, NUM_REQ*`IO_PINS: per-core pin mask; core k owns slice [k*`IO_PINS +: `IO_PINS].
- `gnt`, output, NUM_REQ: one-hot grant, combinational in the request cycle.
- `rd_valid`, output, 1: result-valid pulse.
- `rd_id`, output, ID_W: id of the requester that owns the result.
- `rd_data`, output, `IO_PINS: compressed pins, with the lowest-order masked pin at bit 0.
- `rd_count`, output, CNT_W: number of set bits in the granted mask.

## Operation
- Synchronizer: `io_in` passes through `SYNC_STAGES` flops, giving `io_sync`.
- Arbiter: rotating pointer `ptr` (ID_W bits).
  - Winner is the first asserted `req[i]`, scanning i = ptr, ptr+1, … modulo NUM_REQ.
  - `gnt` is one-hot on the winner, or all zero when `req` is 0.
  - On a grant, `ptr` becomes (winner+1) mod NUM_REQ. With no grant, `ptr` holds.
- Handshake: a requester must hold `req` and its mask stable until it sees `gnt`. If `req` stays high in the cycle after the grant, that is a new request.
- Stage 1 registers, loaded every cycle:
  - `s1_valid` ← |req
  - `s1_id` ← winner
  - `s1_mask` ← winner's mask
  - `s1_pins` ← `io_sync`
  - `s1_mask` is loaded as 0 when there is no grant.
- Stage 2 registers:
  - `rd_data` ← compress(`s1_pins`, `s1_mask`)
  - `rd_count` ← popcount(`s1_mask`)
  - `rd_id` ← `s1_id`
  - `rd_valid` ← `s1_valid`
- Width rule: `rd_data` bits at index ≥ `rd_count` are always 0.
- `rd_data`, `rd_id` and `rd_count` may only change when `rd_valid` is 1, or after reset. Otherwise they hold their last value.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `rd_id`=0, `rd_count`=0, `ptr`=0, all synchronizer and stage flops 0. `gnt` follows `req` with `ptr`=0.
- Latency: a request granted in cycle t produces `rd_valid`=1 in cycle t+2. The result uses the `io_sync` value sampled at the end of cycle t.
- Throughput: one grant per cycle. Back-to-back grants give back-to-back `rd_valid` pulses, in grant order.
- Pin-change latency: an `io_in` edge is visible in `io_sync` `SYNC_STAGES` cycles later.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,…,NUM_REQ-1,0,… Any requester waits at most NUM_REQ-1 cycles.
- Empty mask: a grant still occurs, and the response is `rd_valid`=1, `rd_data`=0, `rd_count`=0.
- Full mask: `rd_data` = `s1_pins` and `rd_count` = `IO_PINS.
- Reset mid-operation: in-flight stage 1 and stage 2 contents are discarded. No `rd_valid` pulse appears in the cycle after `rst` is sampled. `ptr` returns to 0.
- `rst` high together with `req`: `gnt` stays combinational, but grants made while `rst` is high are not captured and produce no response.

## Structure
- `IO_PINS comes from the shared project defines header. No new package is needed; `NUM_REQ` is a module parameter.
- One sub-module: the existing `pin_compress`, instantiated once on `s1_pins`/`s1_mask`.
- The arbiter, synchronizer and popcount are written inline.

## Test plan
Unless stated otherwise: NUM_REQ=4, `IO_PINS=16, SYNC_STAGES=2.
- Single read: `io_in`=16'h9D35 held stable; req=4'b0001; mask0=16'h4945. Expect gnt=4'b0001 in the request cycle. Two cycles later: rd_valid=1, rd_id=0, rd_data=16'h001B, rd_count=6.
- Round-robin: req=4'b1111 held for 8 cycles. Expect gnt sequence 1,2,4,8,1,2,4,8 and rd_id sequence 0,1,2,3,0,1,2,3, with rd_valid high for 8 consecutive cycles.
- Pointer skip: after a grant to core 1, set req=4'b0101. Expect the grant to core 2, then core 0.
- Mask extremes: mask=16'h0000 gives rd_data=0, rd_count=0. mask=16'hFFFF with `io_in`=16'hA5C3 gives rd_data=16'hA5C3, rd_count=16.
- Synchronizer: `io_in` steps from 16'h0000 to 16'hFFFF at cycle t, with continuous full-mask reads from one core. Grants at cycles t and t+1 return 0; the grant at t+2 returns 16'hFFFF.
- Reset mid-flight: grant at cycle t, `rst` asserted at t+1 for one cycle. Expect no rd_valid pulse, ptr=0, and outputs reading zero afterwards.
